seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Downstream consumer of the 7-segment display-select stage: takes the selected 32-bit display word (eight hex nibbles) and drives an 8-digit, common-anode, time-multiplexed 7-segment display. The block handles:
- the per-digit prescaler and scan counter;
- a per-frame snapshot of the input word, so no digit ever shows a half-updated value;
- hex-to-segment decode, decimal points, leading-zero suppression and per-digit blink;
- anti-ghosting dead time between digits.

All outputs are registered.

## Interface
- `SCAN_DIV`, 50000: clk cycles per digit slot; legal range 4..65535.
- `DEAD`, 2: cycles at the start of each slot during which all anodes are off; must be < `SCAN_DIV`.
- `BLINK_FRAMES`, 64: frames per blink half-period; legal range 1..255.
- `clk`  in  1  system clock. All state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `disp_num`  in  32  display word; nibble k drives digit k (digit 0 is rightmost).
- `dp_en`  in  8  decimal point on, per digit.
- `blink_en`  in  8  per-digit blink enable.
- `lz_blank`  in  1  suppress leading zeros.
- `an_n`  out  8  digit enables, active-low.
- `seg_n`  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- `frame_tick`  out  1  one-cycle pulse at each frame start.

## Operation
- Prescaler `pcnt` counts 0..`SCAN_DIV`-1 and then wraps.
- At `pcnt`=`SCAN_DIV`-1 the digit index `idx` increments modulo 8.
- When `idx` wraps 7→0:
  - `frame_tick` asserts for the next cycle;
  - `disp_num`, `dp_en`, `blink_en` and `lz_blank` are captured into shadow registers;
  - the blink frame counter advances.
- Between frames, input changes have no visible effect.
- Blink counter counts 0..`BLINK_FRAMES`-1. On wrap it toggles `blink_ph`. Reset value is 0 (visible phase).
- Leading-zero mask, computed from the shadow word:
  - digit k is suppressed iff `lz_blank`=1, k≠0, and nibbles 7..k are all 0;
  - digit 0 is never suppressed;
  - a suppressed digit's dp still follows `dp_en`.
- Blanking rule for digit k:
  - blank all segments if (`blink_en`[k] & `blink_ph`);
  - else blank a/b/…/g only if it is LZ-suppressed;
  - else show the decoded nibble.
- Decode is standard hex, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - `seg_n` is the bitwise inverse.
- Anode drive:
  - `an_n`[idx]=0 only when `pcnt` ≥ `DEAD`;
  - otherwise `an_n`=FF.
  - `seg_n` is valid for the whole slot.
- Reset values: `an_n`=FF, `seg_n`=FF, `frame_tick`=0.
- Reset state: `idx`=0, `pcnt`=0, `blink_ph`=0, blink counter 0, shadow registers 0.
- First frame after reset shows the shadow contents, i.e. "00000000" with LZ off.
- Asserting reset mid-slot forces all outputs to reset values immediately.

## Timing
- Outputs are registered one cycle behind the internal `pcnt`/`idx` state.
- Digit k's anode goes low at cycle (slot start + `DEAD` + 1) and high at (slot end + 1).
- Snapshot latency: an input change is displayed at most 8·`SCAN_DIV`+1 cycles later. The new value appears on digit 0 in the first slot after the capture.
- If `disp_num` changes in the same cycle as the capture, the new value is captured.
- Full frame period is 8·`SCAN_DIV` cycles. Blink period is 2·`BLINK_FRAMES` frames.

## Structure
- Package `seven_seg_pkg`:
  - 16-entry hex-to-segment constant table;
  - `SEG_BLANK`=7'h00 constant;
  - digit count constant 8.
- Sub-module `seg_hex_decode`: combinational nibble → 7-bit active-high pattern.
- Top block contains:
  - prescaler, index and blink counters;
  - shadow registers and LZ mask;
  - output registers.

## Test plan
Unless noted, parameters are `SCAN_DIV`=4, `DEAD`=1, `BLINK_FRAMES`=2.
- Reset: hold `rst`=0 and toggle clk → `an_n`=FF, `seg_n`=FF, `frame_tick`=0. Release → first `frame_tick` after 32 cycles.
- Scan/decode:
  - `disp_num`=76543210, `dp_en`=00, then wait one frame;
  - → in slot k, `an_n`=~(1<<k) for 3 cycles and FF for 1 cycle;
  - → `seg_n`[6:0] = ~table[k] (slot 0 = 40, slot 1 = 79).
- Snapshot: change `disp_num` from 11111111 to 22222222 mid-frame → remaining slots still show 1. The next frame shows 2 on all digits.
- LZ blanking, `lz_blank`=1:
  - `disp_num`=00000A05 → digits 7..3 `seg_n`[6:0]=7F, digit 2=08, digit 1=40, digit 0=12;
  - `disp_num`=0 → only digit 0 shows 40.
- Blink/dp: `blink_en`=01, `dp_en`=01 → digit 0 has `seg_n`=FF during odd blink phases (frames 2–3, 6–7…). In visible phases `seg_n`[7]=0.
- Async reset mid-slot: assert `rst`=0 between clock edges → `an_n` goes FF without waiting for a clock edge, and scan restarts at `idx`=0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
package seven_seg_pkg;

    // Number of digits on the display.
    localparam int NUM_DIGITS = 8;

    // Pattern with all a..g segments off (active-high).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex nibble to active-high gfedcba pattern.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_seg_scan_decode.sv
// Combinational hex nibble to 7-segment (gfedcba, active-high) decoder.
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seven_seg_scan.sv
// 8-digit common-anode 7-segment scanner: prescaler, digit index, per-frame
// input snapshot, leading-zero suppression, blink and anode dead time.
// Every output is registered one cycle behind the internal pcnt/idx state.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  dp_en,
    input  logic [7:0]  blink_en,
    input  logic        lz_blank,
    output logic [7:0]  an_n,
    output logic [7:0]  seg_n,
    output logic        frame_tick
);

    localparam logic [15:0] PCNT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEAD_CYC  = 16'(DEAD);
    localparam logic [7:0]  BCNT_LAST = 8'(BLINK_FRAMES - 1);

    logic [15:0] pcnt;
    logic [2:0]  idx;
    logic [7:0]  bcnt;
    logic        blink_ph;

    logic [31:0] sh_num;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_blink;
    logic        sh_lz;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic [7:0]            an_next;
    logic [7:0]            seg_next;

    assign slot_end  = (pcnt == PCNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);

    // Prescaler and digit index; idx wraps 7->0 by natural 3-bit overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= 3'(idx + 3'd1);
        end else begin
            pcnt <= 16'(pcnt + 16'd1);
        end
    end

    // Frame-boundary snapshot of all display inputs plus the blink frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_num   <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
            sh_lz    <= 1'b0;
            bcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (frame_end) begin
            sh_num   <= disp_num;
            sh_dp    <= dp_en;
            sh_blink <= blink_en;
            sh_lz    <= lz_blank;
            if (bcnt == BCNT_LAST) begin
                bcnt     <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                bcnt <= 8'(bcnt + 8'd1);
            end
        end
    end

    // Digit k is a leading zero when all nibbles from 7 down to k are zero.
    always_comb begin
        lz_mask = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            lz_mask[k] = sh_lz && ((sh_num >> (4 * k)) == 32'd0);
        end
    end

    assign cur_nib = sh_num[{idx, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Next output values: blink blanks everything, LZ blanks a..g but keeps dp.
    always_comb begin
        seg_next = 8'hFF;
        if (sh_blink[idx] && blink_ph) begin
            seg_next = 8'hFF;
        end else if (lz_mask[idx]) begin
            seg_next = ~{sh_dp[idx], SEG_BLANK};
        end else begin
            seg_next = ~{sh_dp[idx], cur_seg};
        end
        an_next = (pcnt >= DEAD_CYC) ? ~(8'd1 << idx) : 8'hFF;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_n       <= 8'hFF;
            seg_n      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_next;
            seg_n      <= seg_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: randomized and directed stimulus against a
// cycle-count based reference model of the display.
module tb_seven_seg_scan;

    localparam int SD    = 4;
    localparam int DEADC = 1;
    localparam int BF    = 2;
    localparam int FRAME = 8 * SD;

    logic        clk;
    logic        rst;
    logic [31:0] disp_num;
    logic [7:0]  dp_en;
    logic [7:0]  blink_en;
    logic        lz_blank;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;
    logic        frame_tick;

    int n_checks;
    int n_fail;
    int n_edges;

    logic [16:0] exp_q[$];

    // Snapshots per frame since the last reset; frame 0 is all zeros.
    logic [31:0] snap_num   [256];
    logic [7:0]  snap_dp    [256];
    logic [7:0]  snap_blink [256];
    logic        snap_lz    [256];

    seven_seg_scan #(
        .SCAN_DIV     (SD),
        .DEAD         (DEADC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_num   (disp_num),
        .dp_en      (dp_en),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    // Expected {an_n, seg_n, frame_tick} after the n-th clock edge since reset release.
    function automatic logic [16:0] model(input int n);
        int m, slot, pos, d, f;
        logic [31:0] num;
        logic [3:0]  nib;
        logic [7:0]  an, sg;
        logic        ph, lz;
        m    = n - 1;
        slot = m / SD;
        pos  = m % SD;
        d    = slot % 8;
        f    = slot / 8;
        num  = snap_num[f];
        an   = (pos >= DEADC) ? ~(8'd1 << d) : 8'hFF;
        ph   = ((f / BF) % 2) == 1;
        nib  = 4'((num >> (4 * d)) & 32'hF);
        lz   = snap_lz[f] && (d != 0) && ((num >> (4 * d)) == 32'd0);
        if (snap_blink[f][d] && ph) sg = 8'hFF;
        else sg = ~{snap_dp[f][d], (lz ? 7'h00 : hex7(nib))};
        return {an, sg, (n % FRAME) == 0};
    endfunction

    // Scoreboard producer: track edges since reset, record frame snapshots.
    always @(posedge clk) begin
        if (!rst) begin
            n_edges = 0;
            exp_q.delete();
        end else begin
            n_edges++;
            if (n_edges % FRAME == 0) begin
                snap_num[n_edges / FRAME]   = disp_num;
                snap_dp[n_edges / FRAME]    = dp_en;
                snap_blink[n_edges / FRAME] = blink_en;
                snap_lz[n_edges / FRAME]    = lz_blank;
            end
            exp_q.push_back(model(n_edges));
        end
    end

    // Scoreboard consumer: compare on the falling edge.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an_n", 32'(an_n), 32'(e[16:9]));
            check("seg_n", 32'(seg_n), 32'(e[8:1]));
            check("frame_tick", 32'(frame_tick), 32'(e[0]));
        end
    end

    task automatic run_cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] num, input logic [7:0] dp,
                         input logic [7:0] bl, input logic lz);
        @(negedge clk);
        disp_num = num;
        dp_en    = dp;
        blink_en = bl;
        lz_blank = lz;
    endtask

    initial begin
        int first_tick;
        logic [31:0] r;
        int sh;
        n_checks = 0;
        n_fail   = 0;
        n_edges  = 0;
        snap_num[0] = '0; snap_dp[0] = '0; snap_blink[0] = '0; snap_lz[0] = 1'b0;
        disp_num = '0; dp_en = '0; blink_en = '0; lz_blank = 1'b0;
        rst = 1'b0;

        // Reset held: outputs at reset values.
        run_cycles(4);
        check("rst_an_n", 32'(an_n), 32'hFF);
        check("rst_seg_n", 32'(seg_n), 32'hFF);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);
        rst = 1'b1;

        // First frame_tick 32 cycles after release.
        first_tick = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick && first_tick < 0) first_tick = i;
            if (first_tick >= 0) break;
        end
        check("first_tick_cycle", 32'(first_tick), 32'd32);

        // Plain scan/decode of 76543210.
        drive(32'h7654_3210, 8'h00, 8'h00, 1'b0);
        run_cycles(3 * FRAME);

        // Snapshot: change mid-frame.
        drive(32'h1111_1111, 8'h00, 8'h00, 1'b0);
        run_cycles(2 * FRAME + 13);
        drive(32'h2222_2222, 8'h00, 8'h00, 1'b0);
        run_cycles(2 * FRAME);

        // Leading-zero suppression.
        drive(32'h0000_0A05, 8'h00, 8'h00, 1'b1);
        run_cycles(2 * FRAME);
        drive(32'h0000_0000, 8'h04, 8'h00, 1'b1);
        run_cycles(2 * FRAME);

        // Blink and decimal point on digit 0.
        drive(32'h0000_0008, 8'h01, 8'h01, 1'b0);
        run_cycles(8 * FRAME);

        // Randomized inputs, often with leading zeros.
        for (int it = 0; it < 24; it++) begin
            r  = $urandom;
            sh = $urandom_range(0, 8);
            r  = (sh == 8) ? 32'd0 : (r >> (4 * sh));
            drive(r, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            run_cycles($urandom_range(1, 48));
        end

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_an_n", 32'(an_n), 32'hFF);
        check("async_seg_n", 32'(seg_n), 32'hFF);
        check("async_frame_tick", 32'(frame_tick), 32'h0);
        run_cycles(2);
        rst = 1'b1;
        drive(32'hFEDC_BA98, 8'hA5, 8'h00, 1'b0);
        run_cycles(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
